baud_gen_frac: RTL and testbench

//  Runtime-programmable fractional baud-tick generator for the UART. It replaces the fixed 4-rate table

---
 rtl/baud_gen_frac_if.sv | 41 ++++
 rtl/baud_gen_frac.sv | 143 ++++++++++++++
 tb/tb_baud_gen_frac.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/baud_gen_frac_if.sv
// Purpose: bundles the control, divisor-staging and tick signals of the
// fractional baud generator so the generator and its users share one port.
// Signals:
//   en_i          generator enable
//   rx_busy_i     RX engine mid-frame
//   tx_busy_i     TX engine mid-frame
//   sync_i        restart the tick phase (RX start-bit alignment)
//   div_we_i      write the staged divisor
//   div_int_i     integer cycles per oversample tick
//   div_frac_i    fractional cycles per oversample tick
//   div_pending_o staged divisor not yet applied
//   os_tick_o     one-cycle oversample pulse
//   bit_tick_o    one-cycle pulse on every OverSampleRate-th oversample tick
// The _i/_o suffixes name directions as seen from the generator (slave side).
interface baud_gen_frac_if #(
  parameter int unsigned IntWidth  = 16,
  parameter int unsigned FracWidth = 4
);
  logic                 en_i;
  logic                 rx_busy_i;
  logic                 tx_busy_i;
  logic                 sync_i;
  logic                 div_we_i;
  logic [IntWidth-1:0]  div_int_i;
  logic [FracWidth-1:0] div_frac_i;
  logic                 div_pending_o;
  logic                 os_tick_o;
  logic                 bit_tick_o;

  // Generator side
  modport slave (
    input  en_i, rx_busy_i, tx_busy_i, sync_i, div_we_i, div_int_i, div_frac_i,
    output div_pending_o, os_tick_o, bit_tick_o
  );

  // Controller / UART-engine side
  modport master (
    output en_i, rx_busy_i, tx_busy_i, sync_i, div_we_i, div_int_i, div_frac_i,
    input  div_pending_o, os_tick_o, bit_tick_o
  );
endinterface

// File: rtl/baud_gen_frac.sv
// Purpose: runtime-programmable fractional baud-tick generator for the UART.
// An integer.fraction divisor sets the oversample tick period; the fraction
// is spread out by a phase accumulator whose carry stretches single intervals
// by one cycle, so the long-run period is exact with no cumulative drift.
// Divisor writes are staged and only applied while both UART engines are idle.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     baud_gen_frac_if.slave (enable, busy flags, sync, divisor
//           staging, pending flag, os/bit ticks)
module baud_gen_frac #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned OverSampleRate = 16,
  parameter int unsigned DefaultBaud    = 115200,
  parameter int unsigned IntWidth       = 16,
  parameter int unsigned FracWidth      = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  baud_gen_frac_if.slave    bus
);

  localparam int unsigned OsW  = (OverSampleRate > 1) ? $clog2(OverSampleRate) : 1;
  localparam int unsigned CntW = IntWidth + 1;
  // Divisor in units of 1/2^FracWidth cycle, computed at elaboration time
  localparam longint unsigned DivDefault =
    (longint'(ClockFrequency) << FracWidth) /
    (longint'(DefaultBaud) * longint'(OverSampleRate));
  localparam logic [IntWidth-1:0]  IntDefault  = IntWidth'(DivDefault >> FracWidth);
  localparam logic [FracWidth-1:0] FracDefault = FracWidth'(DivDefault);
  localparam logic [OsW-1:0]       OsLast      = OsW'(OverSampleRate - 1);

  logic [IntWidth-1:0]  int_q, int_d;
  logic [FracWidth-1:0] frac_q, frac_d;
  logic [IntWidth-1:0]  pend_int_q, pend_int_d;
  logic [FracWidth-1:0] pend_frac_q, pend_frac_d;
  logic                 pend_q, pend_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [FracWidth-1:0] acc_q, acc_d;
  logic                 ext_q, ext_d;
  logic [OsW-1:0]       os_cnt_q, os_cnt_d;

  logic [IntWidth-1:0]  int_eff_s;
  logic [CntW-1:0]      last_s;
  logic                 apply_s;
  logic                 os_tick_s;
  logic                 bit_tick_s;
  logic                 carry_s;
  logic [FracWidth-1:0] acc_sum_s;

  // Tick decode from registered state (zero-latency, combinational)
  always_comb begin
    // Divisors below 2 are clamped so a tick can never fire every cycle
    if (int_q < IntWidth'(2)) begin
      int_eff_s = IntWidth'(2);
    end else begin
      int_eff_s = int_q;
    end
    // Last count of the current interval: int_eff + ext - 1
    last_s = {1'b0, int_eff_s} + CntW'(ext_q) - CntW'(1);
    apply_s = pend_q & ~(bus.rx_busy_i | bus.tx_busy_i);
    os_tick_s = bus.en_i & ~bus.sync_i & ~apply_s & (cnt_q == last_s);
    bit_tick_s = os_tick_s & (os_cnt_q == OsLast);
    {carry_s, acc_sum_s} = {1'b0, acc_q} + {1'b0, frac_q};
  end

  // Next-state: divisor staging/apply and the tick counters
  always_comb begin
    int_d       = int_q;
    frac_d      = frac_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ext_d       = ext_q;
    os_cnt_d    = os_cnt_q;

    // A write always lands in the staging registers; a write in the same
    // cycle as an apply keeps the new value pending for the next idle cycle.
    if (bus.div_we_i) begin
      pend_int_d  = bus.div_int_i;
      pend_frac_d = bus.div_frac_i;
      pend_d      = 1'b1;
    end else if (apply_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    // Apply wins over sync; both restart the phase from zero
    if (apply_s) begin
      int_d    = pend_int_q;
      frac_d   = pend_frac_q;
      cnt_d    = '0;
      acc_d    = '0;
      ext_d    = 1'b0;
      os_cnt_d = '0;
    end else if (!bus.en_i || bus.sync_i) begin
      cnt_d    = '0;
      acc_d    = '0;
      ext_d    = 1'b0;
      os_cnt_d = '0;
    end else if (os_tick_s) begin
      cnt_d    = '0;
      acc_d    = acc_sum_s;
      ext_d    = carry_s;
      os_cnt_d = (os_cnt_q == OsLast) ? '0 : os_cnt_q + OsW'(1);
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // State registers with asynchronous reset to the default divisor
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      int_q       <= IntDefault;
      frac_q      <= FracDefault;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ext_q       <= 1'b0;
      os_cnt_q    <= '0;
    end else begin
      int_q       <= int_d;
      frac_q      <= frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ext_q       <= ext_d;
      os_cnt_q    <= os_cnt_d;
    end
  end

  assign bus.div_pending_o = pend_q;
  assign bus.os_tick_o     = os_tick_s;
  assign bus.bit_tick_o    = bit_tick_s;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed testbench for baud_gen_frac. Inputs are driven on the falling edge;
// outputs are observed on the falling edge (or #1 after a drive).
module tb_baud_gen_frac;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  baud_gen_frac_if #(.IntWidth(16), .FracWidth(4)) bus ();

  baud_gen_frac #(
    .ClockFrequency(50_000_000),
    .OverSampleRate(16),
    .DefaultBaud   (115200),
    .IntWidth      (16),
    .FracWidth     (4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance falling edges until an os tick is observed; n = edges advanced
  task automatic wait_tick(output int n, output logic b);
    n = 0;
    b = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.os_tick_o && n < 2000);
    check_val("tick_seen", int'(bus.os_tick_o), 1);
    b = bus.bit_tick_o;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.sync_i = 1'b0;
    bus.div_we_i = 1'b0;
    bus.rx_busy_i = 1'b0;
    bus.tx_busy_i = 1'b0;
    bus.en_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int   n;
    logic b;
    int   pos_err;
    int   nbits;
    int   quiet;

    clk = 1'b0;
    rst_n = 1'b0;
    n_cmp = 0;
    n_mis = 0;
    bus.en_i = 1'b0;
    bus.rx_busy_i = 1'b0;
    bus.tx_busy_i = 1'b0;
    bus.sync_i = 1'b0;
    bus.div_we_i = 1'b0;
    bus.div_int_i = 16'd0;
    bus.div_frac_i = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_os_tick", int'(bus.os_tick_o), 0);
    check_val("rst_bit_tick", int'(bus.bit_tick_o), 0);
    check_val("rst_pending", int'(bus.div_pending_o), 0);
    bus.en_i = 1'b1;
    #1;
    check_val("rst_en_os_tick", int'(bus.os_tick_o), 0);

    // 1: default divisor 27 + 2/16 -> 27 x8 then 28
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(n, b);
    check_val("t1_iv0", n + 1, 27);
    for (int i = 1; i < 9; i++) begin
      wait_tick(n, b);
      check_val($sformatf("t1_iv%0d", i), n, (i == 8) ? 28 : 27);
    end

    // 2: bit tick on every 16th os tick
    do_reset();
    pos_err = 0;
    nbits = 0;
    for (int k = 1; k <= 160; k++) begin
      wait_tick(n, b);
      if (b != ((k % 16) == 0)) pos_err++;
      if (b) nbits++;
    end
    check_val("t2_bit_pos_err", pos_err, 0);
    check_val("t2_bit_count", nbits, 10);

    // 3: busy holds the running divisor while a new one is staged
    bus.tx_busy_i = 1'b1;
    bus.div_int_i = 16'd325;
    bus.div_frac_i = 4'd8;
    bus.div_we_i = 1'b1;
    @(negedge clk);
    bus.div_we_i = 1'b0;
    check_val("t3_pending", int'(bus.div_pending_o), 1);
    wait_tick(n, b);
    check_val("t3_busy_iv0", n + 1, 28);
    wait_tick(n, b);
    check_val("t3_busy_iv1", n, 27);
    check_val("t3_pending_held", int'(bus.div_pending_o), 1);
    // drop busy on a tick cycle: apply suppresses that tick
    bus.tx_busy_i = 1'b0;
    #1;
    check_val("t3_apply_no_tick", int'(bus.os_tick_o), 0);
    wait_tick(n, b);
    check_val("t3_new_iv0", n, 325);
    check_val("t3_pending_clr", int'(bus.div_pending_o), 0);
    for (int i = 1; i < 4; i++) begin
      wait_tick(n, b);
      check_val($sformatf("t3_new_iv%0d", i), n, (i == 2) ? 326 : 325);
    end

    // 5: int=0 and int=1 both clamp to a 2-cycle period
    bus.div_int_i = 16'd0;
    bus.div_frac_i = 4'd0;
    bus.div_we_i = 1'b1;
    @(negedge clk);
    bus.div_we_i = 1'b0;
    #1;
    check_val("t5a_pend", int'(bus.div_pending_o), 1);
    check_val("t5a_apply_no_tick", int'(bus.os_tick_o), 0);
    wait_tick(n, b);
    check_val("t5a_iv0", n, 2);
    wait_tick(n, b);
    check_val("t5a_iv1", n, 2);
    bus.div_int_i = 16'd1;
    bus.div_we_i = 1'b1;
    @(negedge clk);
    bus.div_we_i = 1'b0;
    #1;
    check_val("t5b_apply_no_tick", int'(bus.os_tick_o), 0);
    wait_tick(n, b);
    check_val("t5b_iv0", n, 2);
    wait_tick(n, b);
    check_val("t5b_iv1", n, 2);

    // Last write wins while busy
    bus.rx_busy_i = 1'b1;
    bus.div_int_i = 16'd100;
    bus.div_we_i = 1'b1;
    @(negedge clk);
    bus.div_int_i = 16'd40;
    @(negedge clk);
    bus.div_we_i = 1'b0;
    bus.rx_busy_i = 1'b0;
    wait_tick(n, b);
    check_val("t7_last_write", n, 40);

    // Write in the same cycle as an apply stays pending and applies next
    bus.rx_busy_i = 1'b1;
    bus.div_int_i = 16'd50;
    bus.div_we_i = 1'b1;
    @(negedge clk);
    bus.rx_busy_i = 1'b0;
    bus.div_int_i = 16'd30;
    @(negedge clk);
    bus.div_we_i = 1'b0;
    #1;
    check_val("t9_pend_kept", int'(bus.div_pending_o), 1);
    wait_tick(n, b);
    check_val("t9_second_apply", n, 30);
    check_val("t9_pend_clr", int'(bus.div_pending_o), 0);

    // en low: no ticks; re-enable starts a fresh interval
    bus.en_i = 1'b0;
    quiet = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.os_tick_o) quiet++;
    end
    check_val("t8_en_low_ticks", quiet, 0);
    bus.en_i = 1'b1;
    wait_tick(n, b);
    check_val("t8_en_resume", n + 1, 30);

    // 4: sync re-phases the tick train and restarts the bit count
    do_reset();
    wait_tick(n, b);
    check_val("t4_first", n + 1, 27);
    repeat (10) @(negedge clk);
    bus.sync_i = 1'b1;
    #1;
    check_val("t4_sync_no_tick", int'(bus.os_tick_o), 0);
    @(negedge clk);
    bus.sync_i = 1'b0;
    wait_tick(n, b);
    check_val("t4_after_sync", n + 1, 27);
    pos_err = 0;
    nbits = 0;
    for (int k = 2; k <= 16; k++) begin
      wait_tick(n, b);
      if (b != (k == 16)) pos_err++;
      if (b) nbits++;
    end
    check_val("t4_bit_pos_err", pos_err, 0);
    check_val("t4_bit_count", nbits, 1);
    wait_tick(n, b);
    check_val("t4_iv17", n, 28);
    // sync on a tick cycle suppresses that tick
    bus.sync_i = 1'b1;
    #1;
    check_val("t4_sync_suppress", int'(bus.os_tick_o), 0);
    @(negedge clk);
    bus.sync_i = 1'b0;
    wait_tick(n, b);
    check_val("t4_after_sync2", n + 1, 27);

    // 6: reset mid-operation with a pending divisor
    bus.tx_busy_i = 1'b1;
    bus.div_int_i = 16'd300;
    bus.div_frac_i = 4'd0;
    bus.div_we_i = 1'b1;
    @(negedge clk);
    bus.div_we_i = 1'b0;
    check_val("t6_pend_set", int'(bus.div_pending_o), 1);
    wait_tick(n, b);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_os_tick", int'(bus.os_tick_o), 0);
    check_val("t6_rst_bit_tick", int'(bus.bit_tick_o), 0);
    check_val("t6_rst_pending", int'(bus.div_pending_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.tx_busy_i = 1'b0;
    wait_tick(n, b);
    check_val("t6_iv0", n + 1, 27);
    check_val("t6_pend_after", int'(bus.div_pending_o), 0);
    wait_tick(n, b);
    check_val("t6_iv1", n, 27);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
